// File: rtl/if_id_queue_if.sv
// Handshake bundle between the fetch stage, the IF/ID queue and the decode stage.
// The queue connects through the slave modport. The master modport is for whatever drives it.
interface if_id_queue_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_instr;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [ILEN-1:0] id_instr;
    logic            id_illegal;
    logic [CW-1:0]   count;

    modport slave (
        input  flush,
        input  if_valid,
        output if_ready,
        input  if_pc,
        input  if_instr,
        output id_valid,
        input  id_ready,
        output id_pc,
        output id_instr,
        output id_illegal,
        output count
    );

    modport master (
        output flush,
        output if_valid,
        input  if_ready,
        output if_pc,
        output if_instr,
        input  id_valid,
        output id_ready,
        input  id_pc,
        input  id_instr,
        input  id_illegal,
        input  count
    );
endinterface

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction buffer: a DEPTH-entry circular FIFO of {pc, instr} pairs.
// Handshake flags come only from registered occupancy, and there is no bypass from IF to ID.
// A flush empties the queue so that wrong-path instructions are discarded.
module if_id_queue #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input logic          clk,
    input logic          reset,
    if_id_queue_if.slave q
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full, empty, push, pop;

    // Occupancy flags and qualified transfers; flush suppresses both transfers.
    always_comb begin
        full  = (count_q == FullCount);
        empty = (count_q == '0);
        push  = q.if_valid & ~full & ~q.flush;
        pop   = ~empty & q.id_ready & ~q.flush;
    end

    // Next-state for pointers and count. Power-of-two depth means the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array. It needs no reset because the outputs are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= q.if_pc;
            instr_mem[wr_ptr_q] <= q.if_instr;
        end
    end

    // Head presentation, forced to zero when empty. The all-zero encoding is flagged as illegal.
    always_comb begin
        q.if_ready   = ~full;
        q.id_valid   = ~empty;
        q.count      = count_q;
        q.id_pc      = '0;
        q.id_instr   = '0;
        q.id_illegal = 1'b0;
        if (!empty) begin
            q.id_pc      = pc_mem[rd_ptr_q];
            q.id_instr   = instr_mem[rd_ptr_q];
            q.id_illegal = (instr_mem[rd_ptr_q] == '0);
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue. Inputs and outputs are both handled 1 ns after each rising edge.
module tb_if_id_queue;
    logic clk;
    logic reset;
    int   checks;
    int   passes;

    if_id_queue_if #(.XLEN(64), .ILEN(32), .DEPTH(2)) bus ();

    if_id_queue #(.XLEN(64), .ILEN(32), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic offer(input logic v, input logic [63:0] pc, input logic [31:0] instr);
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_instr = instr;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset        = 1'b0;
        bus.flush    = 1'b0;
        bus.id_ready = 1'b0;
        offer(1'b0, 64'h0, 32'h0);
        step();
        step();
        chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
        chk("rst_if_ready", 64'(bus.if_ready), 64'd1);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_id_pc", bus.id_pc, 64'h0);
        chk("rst_id_instr", 64'(bus.id_instr), 64'h0);
        chk("rst_id_illegal", 64'(bus.id_illegal), 64'd0);
        reset = 1'b1;
        step();

        // Fill with no consumer.
        offer(1'b1, 64'h0, 32'h00500093);
        step();
        chk("fill1_count", 64'(bus.count), 64'd1);
        chk("fill1_id_valid", 64'(bus.id_valid), 64'd1);
        chk("fill1_id_instr", 64'(bus.id_instr), 64'h00500093);
        offer(1'b1, 64'h4, 32'h00a00113);
        step();
        chk("fill2_count", 64'(bus.count), 64'd2);
        chk("fill2_if_ready", 64'(bus.if_ready), 64'd0);
        offer(1'b1, 64'h8, 32'h00000013);
        step();
        chk("full_count", 64'(bus.count), 64'd2);
        chk("full_id_pc_held", bus.id_pc, 64'h0);
        offer(1'b0, 64'h0, 32'h0);

        // Drain in order.
        bus.id_ready = 1'b1;
        chk("drain_head0", bus.id_pc, 64'h0);
        step();
        chk("drain_pc1", bus.id_pc, 64'h4);
        chk("drain_instr1", 64'(bus.id_instr), 64'h00a00113);
        chk("drain_count1", 64'(bus.count), 64'd1);
        step();
        chk("drain_count0", 64'(bus.count), 64'd0);
        chk("drain_id_valid", 64'(bus.id_valid), 64'd0);
        chk("drain_id_pc0", bus.id_pc, 64'h0);

        // Streaming across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            offer(1'b1, 64'h100 + 64'(4 * i), 32'h00000013 + 32'(i));
            step();
            chk("stream_count", 64'(bus.count), 64'd1);
            chk("stream_pc", bus.id_pc, 64'h100 + 64'(4 * i));
        end
        offer(1'b0, 64'h0, 32'h0);
        step();
        chk("stream_end_count", 64'(bus.count), 64'd0);

        // Full with a same-cycle pop must not admit a push.
        bus.id_ready = 1'b0;
        offer(1'b1, 64'h500, 32'h1);
        step();
        offer(1'b1, 64'h504, 32'h2);
        step();
        bus.id_ready = 1'b1;
        offer(1'b1, 64'h508, 32'h3);
        step();
        chk("fullpop_count", 64'(bus.count), 64'd1);
        chk("fullpop_head", bus.id_pc, 64'h504);
        step();
        chk("fullpop_next_count", 64'(bus.count), 64'd1);
        chk("fullpop_next_head", bus.id_pc, 64'h508);
        offer(1'b0, 64'h0, 32'h0);
        step();
        chk("fullpop_empty", 64'(bus.count), 64'd0);

        // Flush with the queue full and an offered instruction.
        bus.id_ready = 1'b0;
        offer(1'b1, 64'h300, 32'h11);
        step();
        offer(1'b1, 64'h304, 32'h12);
        step();
        chk("preflush_count", 64'(bus.count), 64'd2);
        bus.flush    = 1'b1;
        bus.id_ready = 1'b1;
        offer(1'b1, 64'h200, 32'h13);
        step();
        bus.flush = 1'b0;
        offer(1'b0, 64'h0, 32'h0);
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_id_valid", 64'(bus.id_valid), 64'd0);
        chk("flush_if_ready", 64'(bus.if_ready), 64'd1);
        step();
        chk("flush_no_200", 64'(bus.id_valid), 64'd0);

        // Flush with a free slot. The offered instruction is still dropped.
        bus.id_ready = 1'b0;
        offer(1'b1, 64'h310, 32'h21);
        step();
        bus.flush = 1'b1;
        offer(1'b1, 64'h200, 32'h22);
        step();
        bus.flush = 1'b0;
        offer(1'b0, 64'h0, 32'h0);
        chk("flush1_count", 64'(bus.count), 64'd0);
        step();
        chk("flush1_id_valid", 64'(bus.id_valid), 64'd0);
        chk("flush1_id_pc", bus.id_pc, 64'h0);

        // Illegal all-zero encoding.
        offer(1'b1, 64'h40, 32'h00000000);
        step();
        chk("illegal_pc", bus.id_pc, 64'h40);
        chk("illegal_flag", 64'(bus.id_illegal), 64'd1);
        offer(1'b1, 64'h44, 32'h00000013);
        step();
        chk("illegal_stall", 64'(bus.id_illegal), 64'd1);
        chk("illegal_stall_count", 64'(bus.count), 64'd2);
        offer(1'b0, 64'h0, 32'h0);
        bus.id_ready = 1'b1;
        step();
        chk("legal_pc", bus.id_pc, 64'h44);
        chk("legal_flag", 64'(bus.id_illegal), 64'd0);
        step();
        chk("empty_illegal", 64'(bus.id_illegal), 64'd0);

        // Asynchronous reset while the queue holds data.
        bus.id_ready = 1'b0;
        offer(1'b1, 64'h600, 32'h31);
        step();
        offer(1'b1, 64'h604, 32'h32);
        step();
        offer(1'b0, 64'h0, 32'h0);
        chk("prereset_count", 64'(bus.count), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("async_id_valid", 64'(bus.id_valid), 64'd0);
        chk("async_if_ready", 64'(bus.if_ready), 64'd1);
        chk("async_count", 64'(bus.count), 64'd0);
        chk("async_id_pc", bus.id_pc, 64'h0);
        #1;
        reset = 1'b1;
        step();
        chk("postreset_id_valid", 64'(bus.id_valid), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
